// File: rtl/pipe_stage_skid_if.sv
// Beat channel between pipeline stages: valid/ready handshake plus instruction payload.
// The master drives the beat; the slave answers with ready.
interface pipe_stage_skid_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_op;
  logic              wb_enable;

  modport master (
    output valid, pc, mem_address, instr, mem_data, mem_op, wb_enable,
    input  ready
  );

  modport slave (
    input  valid, pc, mem_address, instr, mem_data, mem_op, wb_enable,
    output ready
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with optional two-entry skid buffer, flush and a
// saturating backpressure counter. Payload always comes from the main register.
module pipe_stage_skid #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  pipe_stage_skid_if.slave   up,
  pipe_stage_skid_if.master  dn,
  output logic [STALL_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_op;
    logic              wb_enable;
  } beat_t;

  state_t             state_q;
  state_t             state_d;
  beat_t              main_q;
  beat_t              main_d;
  beat_t              skid_q;
  beat_t              skid_d;
  beat_t              in_beat;
  logic               in_ready_q;
  logic               in_ready_c;
  logic               out_valid_c;
  logic               in_xfer_c;
  logic               out_stall_c;
  logic [STALL_W-1:0] stall_q;

  assign in_beat = '{
    pc:          up.pc,
    mem_address: up.mem_address,
    instr:       up.instr,
    mem_data:    up.mem_data,
    mem_op:      up.mem_op,
    wb_enable:   up.wb_enable
  };

  assign out_valid_c = (state_q != ST_EMPTY);

  // Skid mode exposes a registered ready; the bypass mode lets downstream ready through.
  assign in_ready_c  = (SKID_EN != 0) ? in_ready_q : (~out_valid_c | dn.ready);
  assign in_xfer_c   = up.valid & in_ready_c;
  assign out_stall_c = out_valid_c & ~dn.ready;

  // Next-state and register-load decode; flush wins over every transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (SKID_EN != 0) begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer_c) begin
            main_d  = in_beat;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_xfer_c && dn.ready) begin
            main_d = in_beat;
          end else if (in_xfer_c) begin
            skid_d  = in_beat;
            state_d = ST_SKID;
          end else if (dn.ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (dn.ready) begin
            main_d  = skid_q;
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end else begin
      if (in_xfer_c) begin
        main_d  = in_beat;
        state_d = ST_FULL;
      end else if (out_valid_c && dn.ready) begin
        state_d = ST_EMPTY;
      end
    end

    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_SKID);
    end
  end

  // Saturating count of backpressured cycles; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_stall_c && (stall_q != {STALL_W{1'b1}})) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign up.ready       = in_ready_c;
  assign dn.valid       = out_valid_c;
  assign dn.pc          = main_q.pc;
  assign dn.mem_address = main_q.mem_address;
  assign dn.instr       = main_q.instr;
  assign dn.mem_data    = main_q.mem_data;
  // A bubble must never write back or touch memory.
  assign dn.mem_op      = out_valid_c & main_q.mem_op;
  assign dn.wb_enable   = out_valid_c & main_q.wb_enable;
  assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: skid stage (default and 2-bit stall counter) plus bypass-mode stage.
module tb_pipe_stage_skid;

  logic        clock;
  logic        reset;
  logic        flush0, flush1, flush2;
  logic [15:0] stall0;
  logic [1:0]  stall1;
  logic [15:0] stall2;
  int          vectors;
  int          miscompares;

  pipe_stage_skid_if #(.ADDR_W(32), .DATA_W(32)) up0 ();
  pipe_stage_skid_if #(.ADDR_W(32), .DATA_W(32)) dn0 ();
  pipe_stage_skid_if #(.ADDR_W(32), .DATA_W(32)) up1 ();
  pipe_stage_skid_if #(.ADDR_W(32), .DATA_W(32)) dn1 ();
  pipe_stage_skid_if #(.ADDR_W(32), .DATA_W(32)) up2 ();
  pipe_stage_skid_if #(.ADDR_W(32), .DATA_W(32)) dn2 ();

  pipe_stage_skid #(.ADDR_W(32), .DATA_W(32), .SKID_EN(1), .STALL_W(16)) u0 (
    .clock(clock), .reset(reset), .flush(flush0), .up(up0.slave), .dn(dn0.master),
    .stall_cycles(stall0));
  pipe_stage_skid #(.ADDR_W(32), .DATA_W(32), .SKID_EN(1), .STALL_W(2)) u1 (
    .clock(clock), .reset(reset), .flush(flush1), .up(up1.slave), .dn(dn1.master),
    .stall_cycles(stall1));
  pipe_stage_skid #(.ADDR_W(32), .DATA_W(32), .SKID_EN(0), .STALL_W(16)) u2 (
    .clock(clock), .reset(reset), .flush(flush2), .up(up2.slave), .dn(dn2.master),
    .stall_cycles(stall2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic beat0(input logic v, input logic [31:0] pc, input logic wb, input logic mo);
    up0.valid = v; up0.pc = pc; up0.wb_enable = wb; up0.mem_op = mo;
    up0.instr = pc ^ 32'hA5A5_0000; up0.mem_data = pc + 32'd1; up0.mem_address = pc + 32'd2;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if (dn0.valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", dn0.valid); end
    vectors++; if (up0.ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", up0.ready); end
    vectors++; if (dn0.pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", dn0.pc); end
    vectors++; if (dn0.instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", dn0.instr); end
    vectors++; if (dn0.mem_address !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", dn0.mem_address); end
    vectors++; if ({dn0.mem_op, dn0.wb_enable} !== 2'b00) begin miscompares++; $display("FAIL reset_ctrl: got %b want 00", {dn0.mem_op, dn0.wb_enable}); end
    vectors++; if (stall0 !== 16'd0) begin miscompares++; $display("FAIL reset_stall: got %0d want 0", stall0); end
    vectors++; if (up2.ready !== 1'b1) begin miscompares++; $display("FAIL reset_bypass_ready: got %b want 1", up2.ready); end
  endtask

  task automatic test_basic;
    beat0(1'b1, 32'h100, 1'b1, 1'b0);
    up0.instr = 32'hDEAD_BEEF;
    dn0.ready = 1'b1;
    tick();
    vectors++; if (dn0.valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b want 1", dn0.valid); end
    vectors++; if (dn0.pc !== 32'h100) begin miscompares++; $display("FAIL basic_pc: got %h want 100", dn0.pc); end
    vectors++; if (dn0.wb_enable !== 1'b1) begin miscompares++; $display("FAIL basic_wb: got %b want 1", dn0.wb_enable); end
    vectors++; if (dn0.instr !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL basic_instr: got %h want deadbeef", dn0.instr); end
    vectors++; if (dn0.mem_data !== 32'h101) begin miscompares++; $display("FAIL basic_mem_data: got %h want 101", dn0.mem_data); end
    beat0(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    vectors++; if (dn0.valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain_valid: got %b want 0", dn0.valid); end
    vectors++; if (dn0.wb_enable !== 1'b0) begin miscompares++; $display("FAIL basic_bubble_wb: got %b want 0", dn0.wb_enable); end
    vectors++; if (dn0.pc !== 32'h100) begin miscompares++; $display("FAIL basic_hold_pc: got %h want 100", dn0.pc); end
  endtask

  task automatic test_skid;
    beat0(1'b1, 32'h0, 1'b1, 1'b0);
    dn0.ready = 1'b1;
    tick();
    beat0(1'b1, 32'h4, 1'b1, 1'b0);
    dn0.ready = 1'b0;
    tick();
    vectors++; if (up0.ready !== 1'b0) begin miscompares++; $display("FAIL skid_in_ready: got %b want 0", up0.ready); end
    vectors++; if (dn0.pc !== 32'h0) begin miscompares++; $display("FAIL skid_pc0: got %h want 0", dn0.pc); end
    vectors++; if (stall0 !== 16'd1) begin miscompares++; $display("FAIL skid_stall1: got %0d want 1", stall0); end
    beat0(1'b1, 32'h8, 1'b1, 1'b0);
    tick();
    vectors++; if (dn0.pc !== 32'h0) begin miscompares++; $display("FAIL skid_hold_pc: got %h want 0", dn0.pc); end
    vectors++; if (up0.ready !== 1'b0) begin miscompares++; $display("FAIL skid_hold_ready: got %b want 0", up0.ready); end
    dn0.ready = 1'b1;
    tick();
    vectors++; if (dn0.pc !== 32'h4) begin miscompares++; $display("FAIL skid_pc4: got %h want 4", dn0.pc); end
    vectors++; if ({dn0.valid, up0.ready} !== 2'b11) begin miscompares++; $display("FAIL skid_refill_hs: got %b want 11", {dn0.valid, up0.ready}); end
    tick();
    vectors++; if (dn0.pc !== 32'h8) begin miscompares++; $display("FAIL skid_pc8: got %h want 8", dn0.pc); end
    beat0(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    vectors++; if (dn0.valid !== 1'b0) begin miscompares++; $display("FAIL skid_drained: got %b want 0", dn0.valid); end
    vectors++; if (stall0 !== 16'd2) begin miscompares++; $display("FAIL skid_stall2: got %0d want 2", stall0); end
  endtask

  task automatic test_stall_sat;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    beat0(1'b1, 32'h10, 1'b1, 1'b1);
    up1.valid = 1'b1; up1.pc = 32'h10;
    dn0.ready = 1'b0; dn1.ready = 1'b0;
    tick();
    beat0(1'b0, 32'h0, 1'b0, 1'b0);
    up1.valid = 1'b0;
    vectors++; if (stall1 !== 2'd0) begin miscompares++; $display("FAIL stall_start: got %0d want 0", stall1); end
    for (int i = 0; i < 2; i++) tick();
    vectors++; if (stall1 !== 2'd2) begin miscompares++; $display("FAIL stall_sat_mid: got %0d want 2", stall1); end
    for (int i = 0; i < 3; i++) tick();
    vectors++; if (stall0 !== 16'd5) begin miscompares++; $display("FAIL stall_count5: got %0d want 5", stall0); end
    vectors++; if (stall1 !== 2'd3) begin miscompares++; $display("FAIL stall_saturate: got %0d want 3", stall1); end
    vectors++; if (dn0.pc !== 32'h10) begin miscompares++; $display("FAIL stall_hold_pc: got %h want 10", dn0.pc); end
  endtask

  task automatic test_flush;
    beat0(1'b1, 32'h20, 1'b1, 1'b1);
    tick();
    vectors++; if ({dn0.valid, up0.ready} !== 2'b10) begin miscompares++; $display("FAIL flush_enter_skid: got %b want 10", {dn0.valid, up0.ready}); end
    vectors++; if (stall0 !== 16'd6) begin miscompares++; $display("FAIL flush_pre_stall: got %0d want 6", stall0); end
    beat0(1'b1, 32'h24, 1'b1, 1'b1);
    flush0 = 1'b1;
    dn0.ready = 1'b1;
    tick();
    flush0 = 1'b0;
    beat0(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++; if (dn0.valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", dn0.valid); end
    vectors++; if ({dn0.wb_enable, dn0.mem_op} !== 2'b00) begin miscompares++; $display("FAIL flush_ctrl: got %b want 00", {dn0.wb_enable, dn0.mem_op}); end
    vectors++; if (up0.ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready: got %b want 1", up0.ready); end
    vectors++; if (stall0 !== 16'd6) begin miscompares++; $display("FAIL flush_stall_kept: got %0d want 6", stall0); end
    tick();
    vectors++; if (dn0.valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped: got %b want 0", dn0.valid); end
  endtask

  task automatic test_bypass;
    up2.valid = 1'b1; up2.pc = 32'h40; up2.mem_op = 1'b1; up2.wb_enable = 1'b1;
    dn2.ready = 1'b0;
    tick();
    up2.valid = 1'b0;
    #1;
    vectors++; if (up2.ready !== 1'b0) begin miscompares++; $display("FAIL bypass_ready_low: got %b want 0", up2.ready); end
    dn2.ready = 1'b1;
    #1;
    vectors++; if (up2.ready !== 1'b1) begin miscompares++; $display("FAIL bypass_ready_follow: got %b want 1", up2.ready); end
    dn2.ready = 1'b0;
    #1;
    vectors++; if (up2.ready !== 1'b0) begin miscompares++; $display("FAIL bypass_ready_drop: got %b want 0", up2.ready); end
    dn2.ready = 1'b1;
    up2.valid = 1'b1; up2.pc = 32'h44;
    tick();
    vectors++; if (dn2.pc !== 32'h44) begin miscompares++; $display("FAIL b2b_pc44: got %h want 44", dn2.pc); end
    up2.pc = 32'h48;
    tick();
    vectors++; if (dn2.pc !== 32'h48) begin miscompares++; $display("FAIL b2b_pc48: got %h want 48", dn2.pc); end
    vectors++; if ({dn2.valid, dn2.mem_op} !== 2'b11) begin miscompares++; $display("FAIL b2b_valid_op: got %b want 11", {dn2.valid, dn2.mem_op}); end
    up2.valid = 1'b0;
    tick();
    vectors++; if ({dn2.valid, dn2.mem_op, dn2.wb_enable} !== 3'b000) begin miscompares++; $display("FAIL bypass_bubble: got %b want 000", {dn2.valid, dn2.mem_op, dn2.wb_enable}); end
  endtask

  task automatic test_reset_in_skid;
    beat0(1'b1, 32'h60, 1'b1, 1'b1);
    dn0.ready = 1'b0;
    tick();
    beat0(1'b1, 32'h64, 1'b1, 1'b1);
    tick();
    vectors++; if (up0.ready !== 1'b0) begin miscompares++; $display("FAIL rst_skid_reached: got %b want 0", up0.ready); end
    reset = 1'b1;
    flush0 = 1'b1;
    tick();
    reset = 1'b0;
    flush0 = 1'b0;
    beat0(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++; if ({dn0.valid, up0.ready} !== 2'b01) begin miscompares++; $display("FAIL rst_skid_hs: got %b want 01", {dn0.valid, up0.ready}); end
    vectors++; if (dn0.pc !== 32'h0 || dn0.instr !== 32'h0 || dn0.mem_data !== 32'h0 || dn0.mem_address !== 32'h0) begin
      miscompares++; $display("FAIL rst_skid_payload: got pc=%h instr=%h want all 0", dn0.pc, dn0.instr);
    end
    vectors++; if ({dn0.mem_op, dn0.wb_enable} !== 2'b00) begin miscompares++; $display("FAIL rst_skid_ctrl: got %b want 00", {dn0.mem_op, dn0.wb_enable}); end
    vectors++; if (stall0 !== 16'd0) begin miscompares++; $display("FAIL rst_skid_stall: got %0d want 0", stall0); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    flush0 = 1'b0; flush1 = 1'b0; flush2 = 1'b0;
    beat0(1'b0, 32'h0, 1'b0, 1'b0);
    dn0.ready = 1'b0;
    up1.valid = 1'b0; up1.pc = '0; up1.mem_address = '0; up1.instr = '0; up1.mem_data = '0;
    up1.mem_op = 1'b0; up1.wb_enable = 1'b0; dn1.ready = 1'b0;
    up2.valid = 1'b0; up2.pc = '0; up2.mem_address = '0; up2.instr = '0; up2.mem_data = '0;
    up2.mem_op = 1'b0; up2.wb_enable = 1'b0; dn2.ready = 1'b0;
    test_reset();
    test_basic();
    test_skid();
    test_stall_sat();
    test_flush();
    test_bypass();
    test_reset_in_skid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter ADDR_W, default 32, width of pc and mem_address fields.
REQ-002 Parameter DATA_W, default 32, width of instr and mem_data fields.
REQ-003 Parameter SKID_EN, default 1; 1 = two-entry skid buffer, 0 = single register with combinational ready.
REQ-004 Parameter STALL_W, default 16, width of stall counter.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clock  in  1  rising-edge clock for all state.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  upstream beat present.
REQ-009 in_ready  out  1  stage accepts beat this cycle.
REQ-010 pc_in / mem_address_in  in  ADDR_W  payload fields.
REQ-011 instr_in / mem_data_in  in  DATA_W  payload fields.
REQ-012 mem_op_in / wb_enable_in  in  1  control payload bits.
REQ-013 flush  in  1  discard all held and incoming beats.
REQ-014 out_valid  out  1  downstream beat present.
REQ-015 out_ready  in  1  downstream accepts beat.
REQ-016 pc_out, instr_out, mem_data_out, mem_address_out  out  widths as inputs  held payload.
REQ-017 mem_op_out / wb_enable_out  out  1  control bits, gated by out_valid.
REQ-018 stall_cycles  out  STALL_W  count of backpressured cycles.

Function
REQ-019 Transfer in occurs on edge when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-020 SKID_EN=1 uses a registered state machine with states EMPTY, FULL (main register valid), SKID (main and skid registers valid).
REQ-021 EMPTY: in_valid -> load main, go FULL; else stay.
REQ-022 FULL: in_valid & out_ready -> load main from input, stay FULL; in_valid & !out_ready -> load skid, go SKID; !in_valid & out_ready -> go EMPTY; else hold.
REQ-023 SKID: out_ready -> main <= skid, go FULL; input ignored; else hold.
REQ-024 SKID_EN=1: in_ready is a register output, 1 in EMPTY/FULL, 0 in SKID; no combinational path from out_ready to in_ready.
REQ-025 SKID_EN=0: single register; in_ready = !out_valid | out_ready (combinational); skid state unused.
REQ-026 out_valid = 1 in FULL or SKID; payload outputs always driven from main register.
REQ-027 Latency: accepted beat appears at outputs on next cycle; throughput one beat/cycle when out_ready held 1.
REQ-028 Beats leave in acceptance order; no beat duplicated or dropped except by flush.
REQ-029 mem_op_out and wb_enable_out are 0 whenever out_valid = 0 (bubble never writes back or accesses memory).
REQ-030 Payload registers hold value while not loaded; main payload stable while out_valid & !out_ready.
REQ-031 flush (reset absent): next state EMPTY, skid emptied, incoming beat dropped same cycle, in_ready = 1 next cycle, overrides all transfers.
REQ-032 stall_cycles increments by 1 on each edge where out_valid & !out_ready; saturates at 2^STALL_W-1; not cleared by flush.

Reset
REQ-033 reset has priority over flush and all transfers.
REQ-034 After reset: state EMPTY, out_valid=0, in_ready=1, all payload outputs 0, mem_op_out=0, wb_enable_out=0, stall_cycles=0.
REQ-035 Reset asserted mid-operation (FULL or SKID) discards all held beats on that edge.

Verification
REQ-036 Reset, then in_valid=1 pc_in=0x100 wb_enable_in=1, out_ready=1 -> next cycle out_valid=1 pc_out=0x100 wb_enable_out=1.
REQ-037 Stream pc 0x0,0x4,0x8 with out_ready=0 from second beat -> state SKID, in_ready=0, pc_out=0x0; release out_ready -> outputs 0x0,0x4 in order, 0x8 accepted next, none lost.
REQ-038 Hold out_valid=1, out_ready=0 for 5 cycles -> stall_cycles=5; with STALL_W=2 same stimulus -> saturates at 3.
REQ-039 In SKID, assert flush with in_valid=1 -> next cycle out_valid=0, wb_enable_out=0, in_ready=1; stall_cycles unchanged.
REQ-040 SKID_EN=0, out_valid=1, toggle out_ready 0/1 -> in_ready follows out_ready same cycle; back-to-back beats pass at one per cycle.
REQ-041 Assert reset in SKID state with flush=1 -> all outputs match REQ-034 next cycle.
